// File: rtl/iterative_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The core drives start/op/a/b and observes busy/done/result.
interface iterative_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/iterative_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per cycle, XLEN+1 cycles start-to-done.
// Special cases (divide by zero, signed overflow) finish in one cycle; start is ignored while busy.
module iterative_divider #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  iterative_divider_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic            r_qsign;
  logic            r_rsign;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic            w_signed;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_q;
  logic [XLEN-1:0] w_spec_r;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_sub_ok;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_quo_fix;

  assign w_signed = ~bus.op[0];
  assign w_abs_a  = (w_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_abs_b  = (w_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
  assign w_div0   = (bus.b == '0);
  assign w_ovf    = w_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  assign w_spec_q = w_div0 ? '1 : bus.a;
  assign w_spec_r = w_div0 ? bus.a : '0;

  // Partial remainder stays below the divisor, so XLEN bits suffice outside the trial subtraction.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_sub_ok  = ~w_trial[XLEN];
  assign w_rem_nxt = w_sub_ok ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_sub_ok};
  assign w_quo_fix = r_qsign ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_rsign ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (bus.start) begin
            r_op    <= bus.op;
            r_qsign <= w_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            r_rsign <= w_signed & bus.a[XLEN-1];
            if (w_div0 || w_ovf) begin
              r_result <= bus.op[1] ? w_spec_r : w_spec_q;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_cnt   <= CW'(XLEN);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule
